// File: rtl/handshake_rr_arbiter.sv
// N-to-1 round-robin arbiter into one registered valid/ready stage; 1-cycle latency, 1 beat/cycle.
// Backpressure: o_ready only to the granted requester while the stage is empty or draining. Packet lock under HANDSHAKE_RR_ARBITER_LOCK_EN.
module handshake_rr_arbiter #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [N*W-1:0]  i_value,
  input  logic [N-1:0]    i_valid,
  output logic [N-1:0]    o_ready,
  input  logic [N-1:0]    i_last,
  output logic [W-1:0]    o_value,
  output logic [IW-1:0]   o_id,
  output logic            o_valid,
  input  logic            i_ready
);

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  value;
  } beat_t;

  beat_t         beat_q, beat_d;
  logic          vld_q, vld_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic          m_ready;
  logic [N-1:0]  grant;
  logic          grant_vld;
  logic [IW-1:0] grant_id;
  logic [IW-1:0] ptr_next;
  logic          xfer;

`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
  logic          lock_q, lock_d;
  logic [IW-1:0] lock_id_q, lock_id_d;
`else
  logic          unused_last;
  assign unused_last = ^i_last;
`endif

  assign m_ready = ~vld_q | i_ready;

  // First valid requester at or after ptr, wrapping; a held lock overrides the search.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int i = 0; i < N; i++) begin
      if (!grant_vld && i_valid[(int'(ptr_q) + i) % N]) begin
        grant_vld = 1'b1;
        grant_id  = IW'((int'(ptr_q) + i) % N);
      end
    end
`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
    if (lock_q) begin
      grant_vld = i_valid[lock_id_q];
      grant_id  = lock_id_q;
    end
`endif
    if (grant_vld) grant[grant_id] = 1'b1;
  end

  assign o_ready  = {N{m_ready}} & grant;
  assign xfer     = m_ready & grant_vld;
  assign ptr_next = (grant_id == IW'(N - 1)) ? '0 : grant_id + IW'(1);

  always_comb begin
    beat_d = beat_q;
    vld_d  = vld_q;
    ptr_d  = ptr_q;
`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
`endif
    if (xfer) begin
      beat_d.value = i_value[grant_id*W +: W];
      beat_d.id    = grant_id;
      vld_d        = 1'b1;
`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
      if (i_last[grant_id]) begin
        lock_d = 1'b0;
        ptr_d  = ptr_next;
      end else begin
        lock_d    = 1'b1;
        lock_id_d = grant_id;
      end
`else
      ptr_d = ptr_next;
`endif
    end else if (m_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beat_q <= '0;
      vld_q  <= 1'b0;
      ptr_q  <= '0;
    end else begin
      beat_q <= beat_d;
      vld_q  <= vld_d;
      ptr_q  <= ptr_d;
    end
  end

`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end
`endif

  assign o_value = beat_q.value;
  assign o_id    = beat_q.id;
  assign o_valid = vld_q;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed bench for handshake_rr_arbiter (N=4, W=8): fixed vectors with hand-computed expectations.
module tb_handshake_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic            clock;
  logic            reset_n;
  logic [N*W-1:0]  i_value;
  logic [N-1:0]    i_valid;
  logic [N-1:0]    o_ready;
  logic [N-1:0]    i_last;
  logic [W-1:0]    o_value;
  logic [IW-1:0]   o_id;
  logic            o_valid;
  logic            i_ready;

  int n_chk  = 0;
  int n_pass = 0;

  handshake_rr_arbiter #(.N(N), .W(W), .IW(IW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .i_value (i_value),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_last  (i_last),
    .o_value (o_value),
    .o_id    (o_id),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [IW-1:0] id,
                           input logic [W-1:0] val);
    check_eq({tag, "_vld"}, 32'(o_valid), 32'(v));
    check_eq({tag, "_id"},  32'(o_id),    32'(id));
    check_eq({tag, "_val"}, 32'(o_value), 32'(val));
  endtask

  task automatic check_rdy(input string tag, input logic [N-1:0] exp);
    #1;
    check_eq({tag, "_rdy"}, 32'(o_ready), 32'(exp));
  endtask

  initial begin
    reset_n = 1'b0;
    i_value = {8'h44, 8'h33, 8'h22, 8'h11};
    i_valid = '0;
    i_last  = '0;
    i_ready = 1'b0;
    tick();
    tick();
    check_out("rst", 1'b0, 2'd0, 8'h00);
    check_rdy("rst", 4'b0000);
    reset_n = 1'b1;
    tick();
    check_out("idle", 1'b0, 2'd0, 8'h00);

    // All valid: rotation 0,1,2,3,0,... with no bubbles.
    i_valid = 4'b1111;
    i_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check_rdy($sformatf("rot%0d", j), 4'(1 << (j % 4)));
      tick();
      check_out($sformatf("rot%0d", j), 1'b1, 2'(j % 4), 8'(8'h11 * (j % 4 + 1)));
    end

    // ch1 and ch3 valid, consumer stalls after first beat.
    i_valid = 4'b1010;
    check_rdy("bp_first", 4'b0010);
    tick();
    check_out("bp_first", 1'b1, 2'd1, 8'h22);
    i_ready = 1'b0;
    check_rdy("bp_stall", 4'b0000);
    tick();
    tick();
    check_out("bp_hold", 1'b1, 2'd1, 8'h22);
    i_ready = 1'b1;
    check_rdy("bp_rel", 4'b1000);
    tick();
    check_out("bp_next", 1'b1, 2'd3, 8'h44);

    // ch2 transfer leaves ptr=3; then ch3 before the wrap to ch0.
    i_valid = 4'b0100;
    tick();
    check_out("p3_ch2", 1'b1, 2'd2, 8'h33);
    i_valid = 4'b1001;
    check_rdy("p3_a", 4'b1000);
    tick();
    check_out("p3_a", 1'b1, 2'd3, 8'h44);
    check_rdy("p3_b", 4'b0001);
    tick();
    check_out("p3_b", 1'b1, 2'd0, 8'h11);

    // No request with stage draining: valid drops, payload and id hold.
    i_valid = 4'b0000;
    check_rdy("drain", 4'b0000);
    tick();
    check_out("drain", 1'b0, 2'd0, 8'h11);

    // Beat in flight, then asynchronous reset mid-cycle (ptr would be 2 otherwise).
    i_valid = 4'b0010;
    tick();
    check_out("fly", 1'b1, 2'd1, 8'h22);
    i_valid = 4'b0000;
    i_ready = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check_out("arst", 1'b0, 2'd0, 8'h00);
    check_rdy("arst", 4'b0000);
    reset_n = 1'b1;
    i_ready = 1'b1;
    i_valid = 4'b1010;
    check_rdy("arst_ptr", 4'b0010);
    i_valid = 4'b0100;
    check_rdy("arst_ch2", 4'b0100);
    tick();
    check_out("arst_ch2", 1'b1, 2'd2, 8'h33);

`ifdef HANDSHAKE_RR_ARBITER_LOCK_EN
    // ptr=3: search 3,0 picks ch0, which then holds the lock for three beats.
    i_valid = 4'b0011;
    i_last  = 4'b0000;
    check_rdy("lk0", 4'b0001);
    tick();
    check_out("lk0", 1'b1, 2'd0, 8'h11);
    i_valid = 4'b0010;
    check_rdy("lk_gap0", 4'b0000);
    tick();
    check_out("lk_gap0", 1'b0, 2'd0, 8'h11);
    i_valid = 4'b0011;
    check_rdy("lk1", 4'b0001);
    tick();
    check_out("lk1", 1'b1, 2'd0, 8'h11);
    i_valid = 4'b0010;
    check_rdy("lk_gap1", 4'b0000);
    tick();
    i_valid = 4'b0011;
    i_last  = 4'b0001;
    check_rdy("lk2", 4'b0001);
    tick();
    check_out("lk2", 1'b1, 2'd0, 8'h11);
    i_last  = 4'b0000;
    check_rdy("lk_ch1", 4'b0010);
    tick();
    check_out("lk_ch1", 1'b1, 2'd1, 8'h22);
`endif

    i_valid = '0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/handshake_rr_arbiter.md
Name: handshake_rr_arbiter

Overview:
- N-to-1 round-robin arbiter. Shares one registered valid/ready output stage among N independent valid/ready requester channels.
- Placed in front of a single downstream handshake consumer, e.g. a shared pipeline stage or FIFO, that several producers must feed.
- Output is a registered flipflop stage that sustains 1 beat/cycle and tags every beat with the source requester index.

Parameters:
- N, 4, number of requester channels (2..16).
- W, 8, payload width in bits.
- IW, $clog2(N), width of the requester index.

Ports:
- clock  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- i_value  input  N*W  requester payloads; channel k occupies bits [k*W +: W].
- i_valid  input  N  per-requester valid.
- o_ready  output  N  per-requester ready (grant & output stage free).
- i_last  input  N  per-requester last-beat marker (used only with the optional feature).
- o_value  output  W  registered payload to the consumer.
- o_id  output  IW  registered index of the requester that sourced o_value.
- o_valid  output  1  registered valid to the consumer.
- i_ready  input  1  consumer ready.

Behaviour:
- Reset (async, reset_n=0): o_valid=0, o_value=0, o_id=0, rr pointer ptr=0, lock state cleared. o_ready=0 while o_valid=0 and no request is pending; o_ready is combinational and never X.
- Stage free: m_ready = ~o_valid | i_ready.
- Grant (combinational): the first k with i_valid[k]=1, searched in order ptr, ptr+1, ..., N-1, 0, ..., ptr-1. Exactly one grant or none.
- o_ready[k] = m_ready & grant[k]. o_ready is 0 for all non-granted channels.
- Transfer on channel k: i_valid[k] & o_ready[k]. On a rising edge with a transfer:
  - o_value <= slice k of i_value.
  - o_id <= k.
  - o_valid <= 1.
  - ptr <= (k+1) mod N, wrapping N-1 to 0.
- Rising edge with m_ready=1 and no transfer: o_valid <= 0. o_value and o_id hold.
- m_ready=0 (o_valid=1 & i_ready=0): o_value, o_id, o_valid and ptr all hold. No requester sees ready.
- Latency: 1 cycle from request transfer to o_valid. Throughput: 1 beat/cycle with i_ready held high, including back-to-back beats from different requesters.
- Fairness: with all N requesters continuously valid, grants rotate 0,1,...,N-1,0,... Any requester waits at most N-1 transfers.
- A requester dropping i_valid before transfer is legal. Grant is recomputed every cycle; no state is kept for it.
- Simultaneous output acceptance and new transfer in the same cycle: the new beat replaces the old one, with no bubble.
- Reset asserted mid-operation: the pending output beat is discarded, and ptr and lock return to their reset values immediately.

Optional Feature:
- Macro: HANDSHAKE_RR_ARBITER_LOCK_EN.
- Defined:
  - Packet lock. After a transfer from channel k with i_last[k]=0, the grant is locked to k until a transfer from k with i_last[k]=1.
  - While locked, other requesters see o_ready=0 even if channel k is idle.
  - ptr advances only on the last-beat transfer.
  - Reset clears the lock.
- Undefined: i_last is ignored, there is no lock state, and arbitration is per beat.

Test Plan:
- Reset, then i_valid=4'b0000 -> o_valid=0, o_ready=0000, o_id=0, o_value=0.
- i_valid=4'b1111, i_value={8'h44,8'h33,8'h22,8'h11}, i_ready=1 for 8 cycles -> o_id sequence 0,1,2,3,0,1,2,3 starting 1 cycle after the first grant, each o_value matching its channel, with no bubbles.
- Requesters 1 and 3 valid, i_ready=0 after the first beat -> o_valid=1, o_id=1, o_value=ch1 held, o_ready=0000. Then i_ready=1 -> next beat is o_id=3.
- ptr=3 (after a ch2 transfer) with only ch0 and ch3 valid -> ch3 granted first, then the wrap to ch0 is granted next.
- Beat in flight (o_valid=1), reset_n pulsed low mid-cycle -> o_valid drops asynchronously to 0. After release, a ch2 request is granted (ptr=0 search finds ch2).
- LOCK_EN defined: ch0 sends 3 beats with i_last=0,0,1 while ch1 is continuously valid -> o_id=0,0,0 then 1. Ch1 sees o_ready=0 during the ch0 gap cycles.
